// File: rtl/l15_anycore_req_arbiter_pkg.sv
// Shared definitions for the anycore-to-L1.5 request arbiter.
//   - Requester class encodings (IF=0, LD=1, ST=2)
//   - FSM state constants
//   - L1.5 request type codes (IMISS_RQ / LOAD_RQ / STORE_RQ)
//   - Helpers for round-robin successor and one-hot class masks
package l15_anycore_req_arbiter_pkg;

    localparam logic [1:0] CLS_IF = 2'd0;
    localparam logic [1:0] CLS_LD = 2'd1;
    localparam logic [1:0] CLS_ST = 2'd2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    localparam logic [4:0] IMISS_RQ = 5'b10000;
    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] STORE_RQ = 5'b00001;

    // Round-robin successor: IF -> LD -> ST -> IF
    function automatic logic [1:0] cls_next(input logic [1:0] c);
        case (c)
            CLS_IF:  return CLS_LD;
            CLS_LD:  return CLS_ST;
            default: return CLS_IF;
        endcase
    endfunction

    function automatic logic [2:0] cls_onehot(input logic [1:0] c);
        case (c)
            CLS_IF:  return 3'b001;
            CLS_LD:  return 3'b010;
            CLS_ST:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/l15_anycore_rr_pick3.sv
// Combinational 3-way round-robin picker.
//   pend  : pending request vector, bit index = class encoding
//   ptr   : class with highest priority this round
//   grant : first pending class at or after ptr (IF -> LD -> ST -> IF)
//   valid : at least one class is pending
module l15_anycore_rr_pick3
    import l15_anycore_req_arbiter_pkg::*;
(
    input  logic [2:0] pend,
    input  logic [1:0] ptr,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;

    always_comb begin
        c0    = ptr;
        c1    = cls_next(c0);
        c2    = cls_next(c1);
        grant = '0;
        valid = 1'b0;
        if ((pend & cls_onehot(c0)) != 3'b000) begin
            grant = c0;
            valid = 1'b1;
        end else if ((pend & cls_onehot(c1)) != 3'b000) begin
            grant = c1;
            valid = 1'b1;
        end else if ((pend & cls_onehot(c2)) != 3'b000) begin
            grant = c2;
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/l15_anycore_req_arbiter.sv
// Request-side controller between the anycore I/D-cache miss ports and the
// single L1.5 transducer request port.
//
// Captures single-cycle request pulses (ifill, load, store), arbitrates them
// round-robin onto the L1.5 val/ack handshake, tracks one outstanding
// transaction per class until its response pulse, and drives busy/stall
// indications back to anycore.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   ic_req_val/addr                 I-cache miss pulse and line address
//   dc_ld_val/addr                  D-cache load miss pulse and address
//   dc_st_val/addr/data/size        store pulse, address, data, size code
//   arb_l15_val/rqtype/address/
//     data/size, l15_arb_ack        L1.5 request handshake
//   resp_ifill/resp_ld/resp_stack   retire pulses from the response encoder
//   ic_busy, dc_busy                anycore stall indications
//   arb_err                         sticky protocol error
//
// Optional build macro L15_ANYCORE_ARB_PERF_EN adds saturating 32-bit
// counters perf_if_cnt, perf_ld_cnt, perf_st_cnt (issued requests) and
// perf_stall_cycles (cycles with val=1 and ack=0).
module l15_anycore_req_arbiter
    import l15_anycore_req_arbiter_pkg::*;
#(
    parameter int unsigned PADDR_W = 40,
    parameter int unsigned DATA_W  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ic_req_val,
    input  logic [PADDR_W-1:0] ic_req_addr,
    input  logic               dc_ld_val,
    input  logic [PADDR_W-1:0] dc_ld_addr,
    input  logic               dc_st_val,
    input  logic [PADDR_W-1:0] dc_st_addr,
    input  logic [DATA_W-1:0]  dc_st_data,
    input  logic [2:0]         dc_st_size,
    output logic               arb_l15_val,
    output logic [4:0]         arb_l15_rqtype,
    output logic [PADDR_W-1:0] arb_l15_address,
    output logic [DATA_W-1:0]  arb_l15_data,
    output logic [2:0]         arb_l15_size,
    input  logic               l15_arb_ack,
    input  logic               resp_ifill,
    input  logic               resp_ld,
    input  logic               resp_stack,
    output logic               ic_busy,
    output logic               dc_busy,
    output logic               arb_err
`ifdef L15_ANYCORE_ARB_PERF_EN
    ,
    output logic [31:0]        perf_if_cnt,
    output logic [31:0]        perf_ld_cnt,
    output logic [31:0]        perf_st_cnt,
    output logic [31:0]        perf_stall_cycles
`endif
);

    logic [0:0]         state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [2:0]         pend_q, pend_d;
    logic [2:0]         outs_q, outs_d;
    logic               err_q, err_d;
    logic [PADDR_W-1:0] if_addr_q, if_addr_d;
    logic [PADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [PADDR_W-1:0] st_addr_q, st_addr_d;
    logic [DATA_W-1:0]  st_data_q, st_data_d;
    logic [2:0]         st_size_q, st_size_d;

    logic [2:0] req_vec;
    logic [2:0] resp_vec;
    logic [2:0] resp_bad;
    logic [2:0] outs_after_resp;
    logic [2:0] req_busy;
    logic [2:0] req_ok;
    logic [2:0] req_bad;
    logic [2:0] issue_vec;
    logic [1:0] pick_grant;
    logic       pick_valid;

    l15_anycore_rr_pick3 u_pick (
        .pend  (pend_q),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        req_vec  = {dc_st_val, dc_ld_val, ic_req_val};
        resp_vec = {resp_stack, resp_ld, resp_ifill};

        // Responses retire before requests are judged, so a response and a
        // new request of the same class in one cycle is legal.
        resp_bad        = resp_vec & ~outs_q;
        outs_after_resp = outs_q & ~resp_vec;
        req_busy        = pend_q | outs_after_resp;
        req_ok          = req_vec & ~req_busy;
        req_bad         = req_vec & req_busy;

        issue_vec = ((state_q == ST_REQ) && l15_arb_ack) ? cls_onehot(grant_q) : 3'b000;

        pend_d = (pend_q & ~issue_vec) | req_ok;
        outs_d = outs_after_resp | issue_vec;
        err_d  = err_q | (|resp_bad) | (|req_bad);

        if_addr_d = req_ok[CLS_IF] ? ic_req_addr : if_addr_q;
        ld_addr_d = req_ok[CLS_LD] ? dc_ld_addr  : ld_addr_q;
        st_addr_d = req_ok[CLS_ST] ? dc_st_addr  : st_addr_q;
        st_data_d = req_ok[CLS_ST] ? dc_st_data  : st_data_q;
        st_size_d = req_ok[CLS_ST] ? dc_st_size  : st_size_q;

        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    state_d = ST_REQ;
                end
            end
            default: begin
                if (l15_arb_ack) begin
                    rr_ptr_d = cls_next(grant_q);
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= CLS_IF;
            rr_ptr_q  <= CLS_IF;
            pend_q    <= '0;
            outs_q    <= '0;
            err_q     <= 1'b0;
            if_addr_q <= '0;
            ld_addr_q <= '0;
            st_addr_q <= '0;
            st_data_q <= '0;
            st_size_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pend_q    <= pend_d;
            outs_q    <= outs_d;
            err_q     <= err_d;
            if_addr_q <= if_addr_d;
            ld_addr_q <= ld_addr_d;
            st_addr_q <= st_addr_d;
            st_data_q <= st_data_d;
            st_size_q <= st_size_d;
        end
    end

    // Request fields are gated by val so the port reads all-zero when idle.
    always_comb begin
        arb_l15_val     = (state_q == ST_REQ);
        arb_l15_rqtype  = '0;
        arb_l15_address = '0;
        arb_l15_data    = '0;
        arb_l15_size    = '0;
        if (arb_l15_val) begin
            case (grant_q)
                CLS_IF: begin
                    arb_l15_rqtype  = IMISS_RQ;
                    arb_l15_address = if_addr_q;
                end
                CLS_LD: begin
                    arb_l15_rqtype  = LOAD_RQ;
                    arb_l15_address = ld_addr_q;
                end
                default: begin
                    arb_l15_rqtype  = STORE_RQ;
                    arb_l15_address = st_addr_q;
                    arb_l15_data    = st_data_q;
                    arb_l15_size    = st_size_q;
                end
            endcase
        end
        ic_busy = pend_q[CLS_IF] | outs_q[CLS_IF];
        dc_busy = pend_q[CLS_LD] | outs_q[CLS_LD] | pend_q[CLS_ST] | outs_q[CLS_ST];
        arb_err = err_q;
    end

`ifdef L15_ANYCORE_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_ld_q, perf_ld_d;
    logic [31:0] perf_st_q, perf_st_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        if (en && (v != '1)) begin
            return v + 32'd1;
        end
        return v;
    endfunction

    always_comb begin
        perf_if_d    = sat_inc(perf_if_q, issue_vec[CLS_IF]);
        perf_ld_d    = sat_inc(perf_ld_q, issue_vec[CLS_LD]);
        perf_st_d    = sat_inc(perf_st_q, issue_vec[CLS_ST]);
        perf_stall_d = sat_inc(perf_stall_q, arb_l15_val & ~l15_arb_ack);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_if_q    <= '0;
            perf_ld_q    <= '0;
            perf_st_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_if_q    <= perf_if_d;
            perf_ld_q    <= perf_ld_d;
            perf_st_q    <= perf_st_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_if_cnt       = perf_if_q;
    assign perf_ld_cnt       = perf_ld_q;
    assign perf_st_cnt       = perf_st_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_l15_anycore_req_arbiter.sv
// Scoreboard bench for l15_anycore_req_arbiter: stimulus pushes expected
// L1.5 requests, a negedge monitor acks and compares presented requests.
module tb_l15_anycore_req_arbiter;

    localparam logic [4:0] T_IMISS = 5'b10000;
    localparam logic [4:0] T_LOAD  = 5'b00000;
    localparam logic [4:0] T_STORE = 5'b00001;

    typedef struct {
        logic [4:0]  rqtype;
        logic [39:0] addr;
        logic [63:0] data;
        logic [2:0]  size;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_req_val = 1'b0;
    logic [39:0] ic_req_addr = '0;
    logic        dc_ld_val = 1'b0;
    logic [39:0] dc_ld_addr = '0;
    logic        dc_st_val = 1'b0;
    logic [39:0] dc_st_addr = '0;
    logic [63:0] dc_st_data = '0;
    logic [2:0]  dc_st_size = '0;
    logic        arb_l15_val;
    logic [4:0]  arb_l15_rqtype;
    logic [39:0] arb_l15_address;
    logic [63:0] arb_l15_data;
    logic [2:0]  arb_l15_size;
    logic        l15_arb_ack = 1'b0;
    logic        resp_ifill = 1'b0;
    logic        resp_ld = 1'b0;
    logic        resp_stack = 1'b0;
    logic        ic_busy;
    logic        dc_busy;
    logic        arb_err;

    int n_checks = 0;
    int n_pass   = 0;
    req_t sb_q[$];
    bit ack_en = 1'b1;
    int ack_delay = 0;
    int vcnt = 0;

    l15_anycore_req_arbiter #(.PADDR_W(40), .DATA_W(64)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ic_req_val      (ic_req_val),
        .ic_req_addr     (ic_req_addr),
        .dc_ld_val       (dc_ld_val),
        .dc_ld_addr      (dc_ld_addr),
        .dc_st_val       (dc_st_val),
        .dc_st_addr      (dc_st_addr),
        .dc_st_data      (dc_st_data),
        .dc_st_size      (dc_st_size),
        .arb_l15_val     (arb_l15_val),
        .arb_l15_rqtype  (arb_l15_rqtype),
        .arb_l15_address (arb_l15_address),
        .arb_l15_data    (arb_l15_data),
        .arb_l15_size    (arb_l15_size),
        .l15_arb_ack     (l15_arb_ack),
        .resp_ifill      (resp_ifill),
        .resp_ld         (resp_ld),
        .resp_stack      (resp_stack),
        .ic_busy         (ic_busy),
        .dc_busy         (dc_busy),
        .arb_err         (arb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] t, input logic [39:0] a, input logic [63:0] d, input logic [2:0] s);
        req_t r;
        r.rqtype = t; r.addr = a; r.data = d; r.size = s;
        sb_q.push_back(r);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (sb_q.size() == 0 && !arb_l15_val && !l15_arb_ack) done = 1'b1;
            else tick();
        end
        chk("wait_idle_done", {63'd0, done}, 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        sb_q.delete();
        rst_n = 1'b1;
    endtask

    // Monitor: compare every presented request against the scoreboard head,
    // ack after ack_delay extra cycles, retire the entry on ack.
    always @(negedge clk) begin
        if (l15_arb_ack) begin
            l15_arb_ack = 1'b0;
            vcnt = 0;
        end else if (arb_l15_val && rst_n) begin
            vcnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_req", {59'd0, arb_l15_rqtype}, 64'h1f);
            end else begin
                chk("req_rqtype", {59'd0, arb_l15_rqtype}, {59'd0, sb_q[0].rqtype});
                chk("req_addr", {24'd0, arb_l15_address}, {24'd0, sb_q[0].addr});
                chk("req_data", arb_l15_data, sb_q[0].data);
                chk("req_size", {61'd0, arb_l15_size}, {61'd0, sb_q[0].size});
            end
            if (ack_en && vcnt > ack_delay) begin
                l15_arb_ack = 1'b1;
                if (sb_q.size() != 0) void'(sb_q.pop_front());
            end
        end else begin
            vcnt = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:0] pat [6];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
        pat[3] = 1'b0; pat[4] = 1'b1; pat[5] = 1'b0;

        do_reset();
        tick();
        chk("rst_val", {63'd0, arb_l15_val}, 64'd0);
        chk("rst_rqtype", {59'd0, arb_l15_rqtype}, 64'd0);
        chk("rst_addr", {24'd0, arb_l15_address}, 64'd0);
        chk("rst_busy", {62'd0, ic_busy, dc_busy}, 64'd0);
        chk("rst_err", {63'd0, arb_err}, 64'd0);

        // Single ifill, ack 3 cycles after val
        ack_delay = 3;
        push(T_IMISS, 40'h00_8000_0040, 64'd0, 3'd0);
        ic_req_val = 1'b1; ic_req_addr = 40'h00_8000_0040;
        tick();
        ic_req_val = 1'b0;
        chk("if_val_lat1", {63'd0, arb_l15_val}, 64'd0);
        chk("if_busy_pend", {63'd0, ic_busy}, 64'd1);
        tick();
        chk("if_val_lat2", {63'd0, arb_l15_val}, 64'd1);
        wait_idle();
        chk("if_busy_outs", {63'd0, ic_busy}, 64'd1);
        resp_ifill = 1'b1;
        tick();
        resp_ifill = 1'b0;
        chk("if_busy_done", {63'd0, ic_busy}, 64'd0);
        chk("if_err", {63'd0, arb_err}, 64'd0);

        // All three in one cycle with pointer at IF; store data path
        do_reset();
        ack_delay = 0;
        push(T_IMISS, 40'h00_0000_1000, 64'd0, 3'd0);
        push(T_LOAD,  40'h00_0000_2008, 64'd0, 3'd0);
        push(T_STORE, 40'h00_0000_3010, 64'h0123456789ABCDEF, 3'd3);
        ic_req_val = 1'b1; ic_req_addr = 40'h00_0000_1000;
        dc_ld_val  = 1'b1; dc_ld_addr  = 40'h00_0000_2008;
        dc_st_val  = 1'b1; dc_st_addr  = 40'h00_0000_3010;
        dc_st_data = 64'h0123456789ABCDEF; dc_st_size = 3'd3;
        tick();
        ic_req_val = 1'b0; dc_ld_val = 1'b0; dc_st_val = 1'b0;
        chk("rr_val_c0", {63'd0, arb_l15_val}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rr_val_c%0d", i + 1), {63'd0, arb_l15_val}, {63'd0, pat[i]});
        end
        wait_idle();
        chk("rr_busy", {62'd0, ic_busy, dc_busy}, 64'd3);
        resp_ifill = 1'b1; resp_ld = 1'b1; resp_stack = 1'b1;
        tick();
        resp_ifill = 1'b0; resp_ld = 1'b0; resp_stack = 1'b0;
        chk("rr_busy_done", {62'd0, ic_busy, dc_busy}, 64'd0);

        // Load after the store carries zero data
        push(T_LOAD, 40'h00_0000_4020, 64'd0, 3'd0);
        dc_ld_val = 1'b1; dc_ld_addr = 40'h00_0000_4020;
        tick();
        dc_ld_val = 1'b0;
        wait_idle();

        // Response and new request of the same class in one cycle
        push(T_LOAD, 40'h00_0000_5028, 64'd0, 3'd0);
        resp_ld = 1'b1; dc_ld_val = 1'b1; dc_ld_addr = 40'h00_0000_5028;
        tick();
        resp_ld = 1'b0; dc_ld_val = 1'b0;
        chk("simul_err", {63'd0, arb_err}, 64'd0);
        wait_idle();
        chk("simul_busy", {63'd0, dc_busy}, 64'd1);

        // Second load before resp_ld: dropped, sticky error
        dc_ld_val = 1'b1; dc_ld_addr = 40'h00_0000_6030;
        tick();
        dc_ld_val = 1'b0;
        chk("dup_err", {63'd0, arb_err}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("dup_no_issue", {63'd0, arb_l15_val}, 64'd0);
        end
        resp_ld = 1'b1;
        tick();
        resp_ld = 1'b0;
        chk("dup_busy", {63'd0, dc_busy}, 64'd0);
        chk("dup_err_sticky", {63'd0, arb_err}, 64'd1);
        do_reset();
        tick();
        chk("err_cleared", {63'd0, arb_err}, 64'd0);

        // Stray store ack with an ifill outstanding
        push(T_IMISS, 40'h00_0000_7040, 64'd0, 3'd0);
        ic_req_val = 1'b1; ic_req_addr = 40'h00_0000_7040;
        tick();
        ic_req_val = 1'b0;
        wait_idle();
        resp_stack = 1'b1;
        tick();
        resp_stack = 1'b0;
        chk("stray_err", {63'd0, arb_err}, 64'd1);
        chk("stray_busy", {62'd0, ic_busy, dc_busy}, 64'd2);
        chk("stray_val", {63'd0, arb_l15_val}, 64'd0);
        resp_ifill = 1'b1;
        tick();
        resp_ifill = 1'b0;
        chk("stray_if_done", {63'd0, ic_busy}, 64'd0);

        // Reset during REQ with ack withheld
        do_reset();
        ack_en = 1'b0;
        push(T_STORE, 40'h00_0000_8048, 64'hDEADBEEF00C0FFEE, 3'd2);
        dc_st_val = 1'b1; dc_st_addr = 40'h00_0000_8048;
        dc_st_data = 64'hDEADBEEF00C0FFEE; dc_st_size = 3'd2;
        tick();
        dc_st_val = 1'b0;
        tick();
        chk("mid_val_up", {63'd0, arb_l15_val}, 64'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_val_drop", {63'd0, arb_l15_val}, 64'd0);
        chk("mid_busy", {62'd0, ic_busy, dc_busy}, 64'd0);
        sb_q.delete();
        rst_n = 1'b1;
        ack_en = 1'b1;
        ack_delay = 1;
        tick();
        push(T_IMISS, 40'h00_0000_9080, 64'd0, 3'd0);
        ic_req_val = 1'b1; ic_req_addr = 40'h00_0000_9080;
        tick();
        ic_req_val = 1'b0;
        tick();
        chk("post_rst_val", {63'd0, arb_l15_val}, 64'd1);
        wait_idle();
        resp_ifill = 1'b1;
        tick();
        resp_ifill = 1'b0;
        chk("post_rst_busy", {62'd0, ic_busy, dc_busy}, 64'd0);
        chk("post_rst_err", {63'd0, arb_err}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
